// File: rtl/score_tracker.sv
// ---------------------------------------------------------------------------
// score_tracker
//
// Game-score stage feeding the per-player display decoders. Raw buttons are
// synchronised and edge-detected. Two 3-bit scores are kept. A small FSM
// (PLAY / WIN / CLEAR) detects the round winner and freezes play until the
// round is cleared.
//
// Parameters:
//   WIN_SCORE  score that ends a round (1..7)
//   BLINK_DIV  blink prescaler width; blink half-period is 2^(BLINK_DIV-1)
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active low
//   btn_p1     raw player-1 button (asynchronous)
//   btn_p2     raw player-2 button (asynchronous)
//   btn_clr    raw round-clear button (asynchronous)
//   c_value1   player-1 score
//   c_value2   player-2 score
//   winner     00 none, 01 player 1, 10 player 2
//   blank      per-digit blank request, bit 1 = player 1, bit 0 = player 2
//   playing    high while the FSM is in PLAY
//
// Optional feature macro: SCORE_BLINK_EN
//   defined   : free-running prescaler; the winner's blank bit follows its MSB
//               while in WIN
//   undefined : no prescaler, blank tied to 2'b00
// ---------------------------------------------------------------------------
module score_tracker #(
    parameter int WIN_SCORE = 5,
    parameter int BLINK_DIV = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_p1,
    input  logic       btn_p2,
    input  logic       btn_clr,
    output logic [2:0] c_value1,
    output logic [2:0] c_value2,
    output logic [1:0] winner,
    output logic [1:0] blank,
    output logic       playing
);

    localparam logic [2:0] WinScore = 3'(WIN_SCORE);

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        WIN   = 2'd1,
        CLEAR = 2'd2
    } state_t;

    // Button vectors are packed as {clr, p2, p1}.
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic [2:0] prev_q;
    logic [2:0] pulse;

    state_t     state_q;
    logic [2:0] score1_q;
    logic [2:0] score2_q;
    logic [2:0] score1_d;
    logic [2:0] score2_d;
    logic [1:0] winner_q;
    logic       playing_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            prev_q  <= 3'b000;
        end else begin
            sync1_q <= {btn_clr, btn_p2, btn_p1};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // One pulse per rising edge of the synchronised level. Because prev is
    // cleared by reset, a button held through reset release pulses once.
    assign pulse = sync2_q & ~prev_q;

    assign score1_d = score1_q + 3'd1;
    assign score2_d = score2_q + 3'd1;

    // Round FSM. Scores never pass WinScore because PLAY is left on the same
    // edge the winning increment lands, so no wrap handling is needed.
    // A clear has priority over score pulses; a simultaneous p1/p2 press
    // cancels out.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= PLAY;
            score1_q  <= 3'd0;
            score2_q  <= 3'd0;
            winner_q  <= 2'b00;
            playing_q <= 1'b1;
        end else begin
            case (state_q)
                PLAY: begin
                    if (pulse[2]) begin
                        state_q   <= CLEAR;
                        playing_q <= 1'b0;
                    end else if (pulse[0] && !pulse[1]) begin
                        score1_q <= score1_d;
                        if (score1_d == WinScore) begin
                            state_q   <= WIN;
                            winner_q  <= 2'b01;
                            playing_q <= 1'b0;
                        end
                    end else if (pulse[1] && !pulse[0]) begin
                        score2_q <= score2_d;
                        if (score2_d == WinScore) begin
                            state_q   <= WIN;
                            winner_q  <= 2'b10;
                            playing_q <= 1'b0;
                        end
                    end
                end
                WIN: begin
                    if (pulse[2]) begin
                        state_q <= CLEAR;
                    end
                end
                CLEAR: begin
                    score1_q  <= 3'd0;
                    score2_q  <= 3'd0;
                    winner_q  <= 2'b00;
                    state_q   <= PLAY;
                    playing_q <= 1'b1;
                end
                default: begin
                    state_q   <= PLAY;
                    playing_q <= 1'b1;
                end
            endcase
        end
    end

    assign c_value1 = score1_q;
    assign c_value2 = score2_q;
    assign winner   = winner_q;
    assign playing  = playing_q;

`ifdef SCORE_BLINK_EN
    logic [BLINK_DIV-1:0] prescale_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            prescale_q <= '0;
        end else begin
            prescale_q <= prescale_q + {{(BLINK_DIV-1){1'b0}}, 1'b1};
        end
    end

    // Only the winner's digit blinks, and only while the round is frozen.
    always_comb begin
        blank = 2'b00;
        if (state_q == WIN) begin
            if (winner_q == 2'b01) begin
                blank = {prescale_q[BLINK_DIV-1], 1'b0};
            end else if (winner_q == 2'b10) begin
                blank = {1'b0, prescale_q[BLINK_DIV-1]};
            end
        end
    end
`else
    logic unusedBlinkDiv;

    assign unusedBlinkDiv = (BLINK_DIV > 1);
    assign blank          = 2'b00;
`endif

endmodule

// File: tb/tb_score_tracker.sv
// ---------------------------------------------------------------------------
// tb_score_tracker
//
// Self-checking bench for score_tracker with WIN_SCORE=5, BLINK_DIV=4.
// A reference model works from sampled button history: a press counts two
// edges after the first edge that sees the button high, provided the edge
// before that saw it low. Directed scenarios are followed by random stimulus.
// Build with SCORE_BLINK_EN defined to check the blink behaviour.
// ---------------------------------------------------------------------------
module tb_score_tracker;

    localparam int WinScore = 5;
    localparam int BlinkDiv = 4;
    localparam int PhPlay   = 0;
    localparam int PhWin    = 1;
    localparam int PhClear  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_p1;
    logic       btn_p2;
    logic       btn_clr;
    logic [2:0] c_value1;
    logic [2:0] c_value2;
    logic [1:0] winner;
    logic [1:0] blank;
    logic       playing;

    int assertions = 0;
    int failures   = 0;

    always #5 clk = ~clk;

    score_tracker #(
        .WIN_SCORE(WinScore),
        .BLINK_DIV(BlinkDiv)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_p1  (btn_p1),
        .btn_p2  (btn_p2),
        .btn_clr (btn_clr),
        .c_value1(c_value1),
        .c_value2(c_value2),
        .winner  (winner),
        .blank   (blank),
        .playing (playing)
    );

    // Reference model state.
    int       mScore1 = 0;
    int       mScore2 = 0;
    int       mWinner = 0;
    int       mPhase  = PhPlay;
    int       mCycles = 0;
    bit [2:0] hP1 = 3'b000;
    bit [2:0] hP2 = 3'b000;
    bit [2:0] hClr = 3'b000;

    // h*[0] is the sample from one edge ago, h*[1] two edges ago, h*[2] three.
    always @(posedge clk) begin : refModel
        bit p1;
        bit p2;
        bit pc;
        int s1;
        int s2;
        int w;
        int ph;
        if (!rst) begin
            mScore1 <= 0;
            mScore2 <= 0;
            mWinner <= 0;
            mPhase  <= PhPlay;
            mCycles <= 0;
            hP1     <= 3'b000;
            hP2     <= 3'b000;
            hClr    <= 3'b000;
        end else begin
            p1 = hP1[1] & ~hP1[2];
            p2 = hP2[1] & ~hP2[2];
            pc = hClr[1] & ~hClr[2];
            s1 = mScore1;
            s2 = mScore2;
            w  = mWinner;
            ph = mPhase;
            if (ph == PhPlay) begin
                if (pc) begin
                    ph = PhClear;
                end else if (p1 && !p2) begin
                    s1 = s1 + 1;
                    if (s1 == WinScore) begin
                        ph = PhWin;
                        w  = 1;
                    end
                end else if (p2 && !p1) begin
                    s2 = s2 + 1;
                    if (s2 == WinScore) begin
                        ph = PhWin;
                        w  = 2;
                    end
                end
            end else if (ph == PhWin) begin
                if (pc) ph = PhClear;
            end else begin
                s1 = 0;
                s2 = 0;
                w  = 0;
                ph = PhPlay;
            end
            mScore1 <= s1;
            mScore2 <= s2;
            mWinner <= w;
            mPhase  <= ph;
            mCycles <= mCycles + 1;
            hP1     <= {hP1[1:0], btn_p1};
            hP2     <= {hP2[1:0], btn_p2};
            hClr    <= {hClr[1:0], btn_clr};
        end
    end

    logic [1:0]  expBlank;
    logic [10:0] expVec;
    logic [10:0] obsVec;
    logic        blinkBit;

    assign blinkBit = (((mCycles >> (BlinkDiv - 1)) & 1) == 1);
    assign obsVec   = {c_value1, c_value2, winner, blank, playing};

    always_comb begin
        expBlank = 2'b00;
`ifdef SCORE_BLINK_EN
        if (mPhase == PhWin) begin
            expBlank = (mWinner == 1) ? {blinkBit, 1'b0} : {1'b0, blinkBit};
        end
`endif
        expVec = {3'(mScore1), 3'(mScore2), 2'(mWinner), expBlank, (mPhase == PhPlay)};
    end

    // Drive inputs at a falling edge and return at the next falling edge.
    task automatic tick(input logic a, input logic b, input logic c, input logic r);
        btn_p1  = a;
        btn_p2  = b;
        btn_clr = c;
        rst     = r;
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            assertions++;
            if (obsVec !== 11'b000_000_00_00_1) begin
                failures++;
                $display("[TB] FAIL reset_values cycle %0d: got %b required %b", i, obsVec, 11'b000_000_00_00_1);
            end
            assertions++;
            if (obsVec !== expVec) begin
                failures++;
                $display("[TB] FAIL reset_model cycle %0d: got %b required %b", i, obsVec, expVec);
            end
        end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_single_press();
        logic [2:0] want;
        for (int i = 1; i <= 10; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b1);
            want = (i >= 3) ? 3'd1 : 3'd0;
            assertions++;
            if (c_value1 !== want || c_value2 !== 3'd0) begin
                failures++;
                $display("[TB] FAIL single_press tick %0d: got %0d/%0d required %0d/0", i, c_value1, c_value2, want);
            end
            assertions++;
            if (obsVec !== expVec) begin
                failures++;
                $display("[TB] FAIL single_press_model tick %0d: got %b required %b", i, obsVec, expVec);
            end
        end
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b1);
            assertions++;
            if (c_value1 !== 3'd1 || c_value2 !== 3'd0) begin
                failures++;
                $display("[TB] FAIL simultaneous tick %0d: got %0d/%0d required 1/0", i, c_value1, c_value2);
            end
        end
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            if (i < 10) tick(1'b0, (i % 2) == 0, 1'b0, 1'b1);
            else tick(1'b0, 1'b0, 1'b0, 1'b1);
            assertions++;
            if (obsVec !== expVec) begin
                failures++;
                $display("[TB] FAIL p2_presses_model tick %0d: got %b required %b", i, obsVec, expVec);
            end
            assertions++;
            if (c_value2 == 3'd5 && (winner !== 2'b10 || playing !== 1'b0)) begin
                failures++;
                $display("[TB] FAIL win_same_edge tick %0d: got winner %b playing %b required 10/0", i, winner, playing);
            end
        end
        assertions++;
        if ({c_value1, c_value2, winner, playing} !== {3'd1, 3'd5, 2'b10, 1'b0}) begin
            failures++;
            $display("[TB] FAIL p2_wins: got %0d/%0d w=%b p=%b required 1/5 w=10 p=0", c_value1, c_value2, winner, playing);
        end
    endtask

    task automatic test_win();
        logic [8:0] want;
        for (int i = 0; i < 8; i++) begin
            tick((i < 6) && ((i % 2) == 0), 1'b0, 1'b0, 1'b1);
            assertions++;
            if (obsVec !== expVec) begin
                failures++;
                $display("[TB] FAIL win_ignore_model tick %0d: got %b required %b", i, obsVec, expVec);
            end
        end
        assertions++;
        if ({c_value1, c_value2, winner} !== {3'd1, 3'd5, 2'b10}) begin
            failures++;
            $display("[TB] FAIL win_ignore: got %0d/%0d w=%b required 1/5 w=10", c_value1, c_value2, winner);
        end
        // Clear out of WIN: scores still held in CLEAR, zeroed one edge later.
        for (int j = 0; j < 4; j++) begin
            tick(j == 0, 1'b0, j == 0, 1'b1);
            tick(1'b0, 1'b0, 1'b0, 1'b1);
            j = j;
            break;
        end
        for (int j = 2; j < 4; j++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b1);
            want = (j == 2) ? {3'd1, 3'd5, 2'b10, 1'b0} : {3'd0, 3'd0, 2'b00, 1'b1};
            assertions++;
            if ({c_value1, c_value2, winner, playing} !== want) begin
                failures++;
                $display("[TB] FAIL clear_from_win step %0d: got %b required %b", j, {c_value1, c_value2, winner, playing}, want);
            end
        end
        // Clear out of PLAY: playing drops for exactly one cycle.
        for (int i = 0; i < 4; i++) tick(i == 0, 1'b0, 1'b0, 1'b1);
        for (int j = 0; j < 5; j++) begin
            tick(1'b0, 1'b0, j == 0, 1'b1);
            assertions++;
            if (playing !== (j != 2) || obsVec !== expVec) begin
                failures++;
                $display("[TB] FAIL clear_from_play step %0d: got %b required playing %b model %b", j, obsVec, (j != 2), expVec);
            end
        end
    endtask

    task automatic test_blink();
        int  lastChange;
        logic prevBit;
        for (int i = 0; i < 12; i++) tick((i < 10) && ((i % 2) == 0), 1'b0, 1'b0, 1'b1);
        assertions++;
        if (winner !== 2'b01 || c_value1 !== 3'd5) begin
            failures++;
            $display("[TB] FAIL p1_wins: got w=%b c1=%0d required w=01 c1=5", winner, c_value1);
        end
        lastChange = -1;
        prevBit    = blank[1];
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b1);
            assertions++;
            if (obsVec !== expVec) begin
                failures++;
                $display("[TB] FAIL blink_model tick %0d: got %b required %b", i, obsVec, expVec);
            end
`ifdef SCORE_BLINK_EN
            assertions++;
            if (blank[0] !== 1'b0 || (blank[1] !== prevBit && lastChange >= 0 && (i - lastChange) != 8)) begin
                failures++;
                $display("[TB] FAIL blink_period tick %0d: got blank %b after %0d ticks required period 8", i, blank, i - lastChange);
            end
            if (blank[1] !== prevBit) lastChange = i;
            prevBit = blank[1];
`else
            assertions++;
            if (blank !== 2'b00) begin
                failures++;
                $display("[TB] FAIL blank_off tick %0d: got %b required 00", i, blank);
            end
`endif
        end
`ifdef SCORE_BLINK_EN
        assertions++;
        if (lastChange < 0) begin
            failures++;
            $display("[TB] FAIL blink_toggle: got no toggle required toggling");
        end
`endif
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, i == 0, 1'b1);
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 12; i++) begin
            tick((i < 10) && ((i % 4) == 0), (i < 10) && ((i % 4) == 2), 1'b0, 1'b1);
        end
        assertions++;
        if (c_value1 !== 3'd3 || c_value2 !== 3'd2) begin
            failures++;
            $display("[TB] FAIL pre_reset_scores: got %0d/%0d required 3/2", c_value1, c_value2);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        assertions++;
        if (obsVec !== 11'b000_000_00_00_1) begin
            failures++;
            $display("[TB] FAIL mid_reset: got %b required %b", obsVec, 11'b000_000_00_00_1);
        end
        for (int i = 1; i <= 5; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b1);
            assertions++;
            if (c_value1 !== ((i >= 3) ? 3'd1 : 3'd0) || obsVec !== expVec) begin
                failures++;
                $display("[TB] FAIL held_through_reset tick %0d: got c1=%0d required %0d", i, c_value1, (i >= 3) ? 1 : 0);
            end
        end
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic a;
        logic b;
        logic c;
        logic r;
        for (int i = 0; i < 600; i++) begin
            a = ($urandom_range(0, 2) == 0);
            b = ($urandom_range(0, 2) == 0);
            c = ($urandom_range(0, 24) == 0);
            r = ($urandom_range(0, 199) != 0);
            tick(a, b, c, r);
            assertions++;
            if (obsVec !== expVec) begin
                failures++;
                $display("[TB] FAIL random tick %0d: got %b required %b", i, obsVec, expVec);
            end
        end
    endtask

    initial begin
        btn_p1  = 1'b0;
        btn_p2  = 1'b0;
        btn_clr = 1'b0;
        rst     = 1'b0;
        test_reset();
        test_single_press();
        test_simultaneous();
        test_win();
        test_blink();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/score_tracker.md
# score_tracker

Game-score stage that sits directly upstream of the per-player `display` decoders. It synchronises and edge-detects raw player buttons and keeps two 3-bit scores, which it drives as the decoders' `c_value` inputs. A small FSM detects the round winner and freezes play until the round is cleared. An optional blink feature tells the downstream multiplexer to blank the winner's digit.

## Interface

- `WIN_SCORE`, default 5: score that ends a round; legal range 1..7.
- `BLINK_DIV`, default 24: width of the blink prescaler; the blink half-period is 2^(BLINK_DIV-1) cycles; legal range ≥2.

- `clk`, input, 1: system clock, rising-edge.
- `rst`, input, 1: reset, synchronous, active-low.
- `btn_p1`, input, 1: raw player-1 button, asynchronous.
- `btn_p2`, input, 1: raw player-2 button, asynchronous.
- `btn_clr`, input, 1: raw round-clear button, asynchronous.
- `c_value1`, output, 3: player-1 score, feeds `display` for player 1.
- `c_value2`, output, 3: player-2 score, feeds `display` for player 2.
- `winner`, output, 2: winner code. 00 means none, 01 means player 1, 10 means player 2; 11 never occurs.
- `blank`, output, 2: per-digit blank request. Bit 1 is player 1, bit 0 is player 2.
- `playing`, output, 1: high while the FSM is in PLAY.

## Operation

- **Input conditioning.** Each button passes through a 2-flop synchroniser, followed by a previous-value flop.
  - Pulse = sync2 & ~prev.
  - This gives exactly one pulse per low-to-high transition, however long the button is held.
- **FSM states.**
  - After reset: PLAY.
  - PLAY:
    - A `p1` pulse alone increments score1; a `p2` pulse alone increments score2.
    - If both pulses arrive in the same cycle, neither score changes.
    - When the incremented score equals `WIN_SCORE`, go to WIN on the same edge and load `winner`.
    - A `clr` pulse goes to CLEAR. `clr` takes priority over `p1`/`p2` pulses in the same cycle.
  - WIN: `p1`/`p2` pulses are ignored and the scores hold. A `clr` pulse goes to CLEAR.
  - CLEAR: lasts one cycle. Scores go to 0, `winner` goes to 00, then go to PLAY. All pulses are ignored in this state.
- **Score arithmetic.** Scores are 3-bit unsigned. The FSM leaves PLAY at `WIN_SCORE` ≤ 7, so a score never exceeds `WIN_SCORE` and never wraps.
- **Outputs.**
  - `c_value1`/`c_value2` are the score registers, driven directly.
  - `playing` is high only in PLAY.
- **Reset values.**
  - `c_value1` = `c_value2` = 3'b000.
  - `winner` = 2'b00, `blank` = 2'b00, `playing` = 1.
  - All synchroniser, prev and prescaler flops = 0.
- **Reset mid-round.** All state returns to the reset values, whatever the FSM state. A button held high through reset release produces one pulse afterwards, because prev was cleared.

## Timing

- **Button latency.** Call the edge that first samples a button high edge k.
  - sync2 goes high at k+1.
  - The pulse is valid between k+1 and k+2.
  - The score/state update happens at edge k+2.
  - Therefore `c_value` changes 2 cycles after the first sampling edge.
- **`winner` and `playing`.** Both update on the same edge as the winning score.
- **CLEAR.** A `clr` pulse at k+1 gives CLEAR at k+2 and zeroed scores plus PLAY at k+3. `playing` is low for exactly one cycle during a clear from PLAY.
- **Outputs.** All outputs are registered or decoded from registered state only. There are no combinational paths from the inputs to the outputs.
- **Minimum press spacing.** Presses must be separated by at least 1 low sample to register twice.

## Configuration

- Macro: `SCORE_BLINK_EN`.
- **Defined:**
  - A free-running BLINK_DIV-bit prescaler counts every cycle from reset.
  - In WIN, the winner's `blank` bit equals the prescaler MSB; the loser's `blank` bit stays 0.
  - Outside WIN, `blank` = 00.
- **Undefined:** the prescaler is not built and `blank` is tied to 2'b00. All other behaviour is identical.

## Test plan

Assume `WIN_SCORE`=5 and `BLINK_DIV`=4 throughout.

1. **Reset.** Drive `rst`=0 for 3 cycles with the buttons low → `c_value1`=`c_value2`=0, `winner`=00, `blank`=00, `playing`=1.
2. **Single press.** Drive `btn_p1` high and keep it high for 10 cycles → `c_value1`=1 exactly 2 cycles after the first sampling edge and stays 1; `c_value2`=0.
3. **Simultaneous press.** Raise `btn_p1` and `btn_p2` on the same cycle → both scores unchanged. Then 5 separate `btn_p2` presses → `c_value2`=5, `winner`=10, `playing`=0 on the same edge.
4. **WIN behaviour.** In WIN, press `btn_p1` 3 times → `c_value1` unchanged. Then press `btn_clr` → one cycle of CLEAR, then scores 0, `winner`=00, `playing`=1.
5. **Blink.** With `SCORE_BLINK_EN` defined and player 1 winning → `blank`[1] toggles every 8 cycles and `blank`[0]=0. With the macro undefined → `blank`=00 throughout.
6. **Mid-round reset.** With scores at 3/2, assert `rst` for 1 cycle while `btn_p1` is held → all outputs return to reset values. After release, `c_value1`=1 two cycles later.
